// File: rtl/mmio_bridge.sv
// mmio_bridge: splits processor data-memory accesses between dmem and a small
// block of game I/O registers (keyboard FIFO, gravity timer, LEDs).
module mmio_bridge #(
  parameter logic [11:0] IO_BASE        = 12'hFF0,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd50000000,
  parameter int unsigned LED_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [11:0]      cpu_address,
  input  logic [31:0]      cpu_data,
  input  logic             cpu_wren,
  output logic [31:0]      cpu_q,
  output logic [11:0]      dmem_address,
  output logic [31:0]      dmem_data,
  output logic             dmem_wren,
  input  logic [31:0]      dmem_q,
  input  logic             kbd_valid,
  input  logic [7:0]       kbd_code,
  output logic [LED_W-1:0] leds
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic             io_sel;
  logic [11:0]      io_off;
  logic [31:0]      io_rdata;

  logic             wr_kbd_status;
  logic             wr_kbd_data;
  logic             wr_period;
  logic             wr_timer_status;
  logic             wr_led;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow;
  logic             push;
  logic             pop;
  logic             drop;

  logic [31:0]      period;
  logic [31:0]      timer_count;
  logic             tick_pending;
  logic             tick_fire;

  // Address decode and dmem passthrough; these stay live during reset.
  always_comb begin
    io_sel          = (cpu_address >= IO_BASE);
    io_off          = cpu_address - IO_BASE;
    dmem_address    = cpu_address;
    dmem_data       = cpu_data;
    dmem_wren       = cpu_wren & ~io_sel;
    wr_kbd_status   = cpu_wren & io_sel & (io_off == 12'd0);
    wr_kbd_data     = cpu_wren & io_sel & (io_off == 12'd1);
    wr_period       = cpu_wren & io_sel & (io_off == 12'd2);
    wr_timer_status = cpu_wren & io_sel & (io_off == 12'd3);
    wr_led          = cpu_wren & io_sel & (io_off == 12'd5);
  end

  // FIFO handshake: a pop makes room for a same-cycle push when full.
  always_comb begin
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == FULL_CNT);
    pop        = wr_kbd_data & ~fifo_empty;
    push       = kbd_valid & (~fifo_full | pop);
    drop       = kbd_valid & fifo_full & ~pop;
  end

  // Timer wrap; a period write overrides the increment for that cycle.
  always_comb begin
    tick_fire = ~wr_period & (period != 32'd0) & (timer_count == period - 32'd1);
  end

  // Scancode storage (no reset needed; validity tracked by count).
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= kbd_code;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (drop)               overflow <= 1'b1;
      else if (wr_kbd_status) overflow <= 1'b0;
    end
  end

  // Gravity timer: period register, free-running count and sticky tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period       <= DEFAULT_PERIOD;
      timer_count  <= 32'd0;
      tick_pending <= 1'b0;
    end else begin
      if (wr_period) begin
        period      <= cpu_data;
        timer_count <= 32'd0;
      end else if (period == 32'd0 || tick_fire) begin
        timer_count <= 32'd0;
      end else begin
        timer_count <= timer_count + 32'd1;
      end
      if (tick_fire)            tick_pending <= 1'b1;
      else if (wr_timer_status) tick_pending <= 1'b0;
    end
  end

  // LED output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       leds <= '0;
    else if (wr_led) leds <= cpu_data[LED_W-1:0];
  end

  // I/O read mux and load-data select.
  always_comb begin
    io_rdata = 32'd0;
    case (io_off)
      12'd0: io_rdata = {16'd0, 8'(fifo_count), 5'd0, overflow, fifo_full, ~fifo_empty};
      12'd1: io_rdata = fifo_empty ? 32'd0 : {24'd0, fifo_mem[rd_ptr]};
      12'd2: io_rdata = period;
      12'd3: io_rdata = {31'd0, tick_pending};
      12'd4: io_rdata = timer_count;
      12'd5: io_rdata = 32'(leds);
      default: io_rdata = 32'd0;
    endcase
    cpu_q = io_sel ? io_rdata : dmem_q;
  end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
Sits between the processor's data-memory port and dmem in the top-level wrapper. Routes word addresses below IO_BASE straight through to dmem. Decodes the top of the 12-bit address space into game I/O registers:
- keyboard scancode FIFO, fed by the PS/2 decoder
- programmable gravity-tick timer
- LED output register

The processor reaches all peripherals with ordinary lw/sw; no new instructions are needed.

Parameters:
IO_BASE, 12'hFF0, first word address decoded as I/O; addresses >= IO_BASE never reach dmem.
FIFO_DEPTH, 8, keyboard FIFO entries; must be a power of 2, minimum 2.
DEFAULT_PERIOD, 32'd50000000, timer period loaded at reset, in clock cycles.
LED_W, 8, width of the LED register.

Ports:
clock  in  1  master clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_address  in  12  word address from the processor (address_dmem).
cpu_data  in  32  store data from the processor.
cpu_wren  in  1  store enable from the processor.
cpu_q  out  32  load data returned to the processor.
dmem_address  out  12  address to dmem (= cpu_address).
dmem_data  out  32  data to dmem (= cpu_data).
dmem_wren  out  1  dmem write enable; cpu_wren gated by the address decode.
dmem_q  in  32  dmem read data.
kbd_valid  in  1  one-cycle strobe: kbd_code holds a new scancode.
kbd_code  in  8  scancode from the PS/2 decoder.
leds  out  LED_W  LED register contents.

Behaviour:
- Decode: io_sel = (cpu_address >= IO_BASE).
  - dmem_wren = cpu_wren & ~io_sel.
  - cpu_q = io_sel ? io_rdata : dmem_q.
  - io_rdata is combinational from cpu_address and the current register state, so I/O loads are available in the same cycle as a dmem read.
- Register map (offset from IO_BASE):
  - +0 KBD_STATUS, read-only fields:
    - bit0 nonempty, bit1 full, bit2 overflow (sticky), bits[15:8] occupancy count.
    - Any write clears overflow.
  - +1 KBD_DATA:
    - Read returns the FIFO head, zero-extended; returns 0 when empty. A read does not pop.
    - Any write pops one entry; a write while empty is ignored.
  - +2 TIMER_PERIOD, read/write:
    - Reset value is DEFAULT_PERIOD.
    - A write also clears TIMER_COUNT to 0.
  - +3 TIMER_STATUS:
    - bit0 tick_pending (sticky).
    - Any write clears it.
  - +4 TIMER_COUNT, read-only; writes are ignored.
  - +5 LED:
    - Write stores cpu_data[LED_W-1:0].
    - Read returns the stored value, zero-extended.
  - +6 to +15: reads return 0; writes are ignored.
- FIFO:
  - Circular buffer with read and write pointers plus a count.
  - Push on a rising edge when kbd_valid=1.
  - Pop on a rising edge when a write hits KBD_DATA.
  - Push and pop in the same cycle:
    - Non-empty: both occur; count is unchanged.
    - Empty: the push occurs and the pop is ignored.
    - Full: both occur; the entry is accepted and nothing is dropped.
  - Push while full with no pop: the code is dropped and overflow is set.
  - If an overflow set and a STATUS clear write occur in the same cycle, the set wins.
  - Pointers wrap modulo FIFO_DEPTH.
- Timer:
  - When period != 0:
    - count increments each cycle.
    - When count == period-1: count <= 0 and tick_pending <= 1.
  - Period 0 halts the timer: count holds 0 and no ticks are generated.
  - If a tick and a STATUS clear occur in the same cycle, the tick wins.
  - A period write takes priority over the increment.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - FIFO is emptied (pointers and count 0); overflow=0.
  - count=0, tick_pending=0, period=DEFAULT_PERIOD, leds=0.
  - Passthrough outputs remain combinational during reset. The reset does not gate dmem_wren beyond the address decode.

Test Plan:
1. sw to 0x010 with data 0xDEADBEEF, then lw 0x010 -> dmem_wren=1 on the store; cpu_q=0xDEADBEEF. sw to 0xFF5 -> dmem_wren=0.
2. Push codes 0x1C, 0x32, 0x21 -> KBD_STATUS=0x0301. KBD_DATA reads 0x1C. Write KBD_DATA -> it reads 0x32; after two more pops STATUS=0, KBD_DATA=0, and a further pop leaves count at 0.
3. Push 9 codes into the depth-8 FIFO -> STATUS=0x0807 and the 9th code is lost. Push and pop in one cycle while full -> count stays 8 and the head advances. Write STATUS -> bit2 clears.
4. Write TIMER_PERIOD=4 -> tick_pending=1 exactly 4 cycles later and count wraps 3->0. Clear STATUS on the cycle a tick fires -> tick_pending stays 1. Period=0 -> count frozen at 0.
5. Assert reset mid-operation with FIFO count=5, leds=0xA5, period=4 -> immediately count=0, leds=0, STATUS=0, TIMER_PERIOD reads DEFAULT_PERIOD.
6. Read 0xFF9 -> 0. Write 0xFF4 -> TIMER_COUNT unaffected and dmem_wren=0.
